// File: rtl/demo_input_scheduler.sv
// Input scheduler for the cursor demo: owns the regime FSM, debounces the regime
// button and paces one valid/ready move request per step tick from the active source.
module demo_input_scheduler #(
  parameter int LOGO_CYCLES     = 100_000_000,
  parameter int STEP_DIV        = 10_000,
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        js_button_a,
  input  logic        js_button_b,
  input  logic        js_button_c,
  input  logic        js_button_d,
  input  logic        js_button_f,
  input  logic [11:0] joystick_data_x,
  input  logic [11:0] joystick_data_y,
  input  logic [15:0] accel_data_x,
  input  logic [15:0] accel_data_y,
  input  logic        move_ready,
  output logic        move_valid,
  output logic [1:0]  move_dx,
  output logic [1:0]  move_dy,
  output logic [1:0]  regime,
  output logic        logo_active,
  output logic [7:0]  overrun_cnt
);

  localparam logic [1:0] LOGO = 2'b00;
  localparam logic [1:0] BTN  = 2'b11;
  localparam logic [1:0] ACC  = 2'b10;
  localparam logic [1:0] JOY  = 2'b01;

  localparam logic [1:0] STEP_ZERO = 2'b00;
  localparam logic [1:0] STEP_POS  = 2'b01;
  localparam logic [1:0] STEP_NEG  = 2'b11;

  localparam int LogoW = (LOGO_CYCLES > 1) ? $clog2(LOGO_CYCLES) : 1;
  localparam int StepW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [LogoW-1:0] LogoLast = LogoW'(LOGO_CYCLES - 1);
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_DIV - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

  logic       btnA_q, btnB_q, btnC_q, btnD_q;
  logic [7:0] joyX_q, joyY_q;
  logic [7:0] accX_q, accY_q;

  logic            fMeta_q, fSync_q;
  logic            dbLevel_q, dbLevel_d;
  logic            dbLevelPrev_q;
  logic [DebW-1:0] dbCnt_q, dbCnt_d;
  logic            modePress;

  logic [1:0]       state_q, state_d;
  logic [LogoW-1:0] logoCnt_q, logoCnt_d;
  logic [StepW-1:0] stepCnt_q, stepCnt_d;
  logic             tick;

  logic [1:0] dirX, dirY;
  logic       accept, sampleTick;
  logic       moveValid_q, moveValid_d;
  logic [1:0] moveDx_q, moveDx_d;
  logic [1:0] moveDy_q, moveDy_d;
  logic [7:0] overrun_q, overrun_d;

  // Only the bits the direction decode looks at are registered; the rest are sunk here.
  logic unusedLowBits;
  assign unusedLowBits = ^{joystick_data_x[3:0], joystick_data_y[3:0],
                           accel_data_x[7:0], accel_data_y[7:0]};

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      btnA_q <= 1'b1;
      btnB_q <= 1'b1;
      btnC_q <= 1'b1;
      btnD_q <= 1'b1;
      joyX_q <= 8'h00;
      joyY_q <= 8'h00;
      accX_q <= 8'h00;
      accY_q <= 8'h00;
    end else begin
      btnA_q <= js_button_a;
      btnB_q <= js_button_b;
      btnC_q <= js_button_c;
      btnD_q <= js_button_d;
      joyX_q <= joystick_data_x[11:4];
      joyY_q <= joystick_data_y[11:4];
      accX_q <= accel_data_x[15:8];
      accY_q <= accel_data_y[15:8];
    end
  end

  // The debounced level flips only after the synchronized button disagrees with it
  // for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_comb begin
    dbLevel_d = dbLevel_q;
    dbCnt_d   = '0;
    if (fSync_q != dbLevel_q) begin
      if (dbCnt_q == DebLast) begin
        dbLevel_d = fSync_q;
      end else begin
        dbCnt_d = dbCnt_q + DebW'(1);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      fMeta_q       <= 1'b0;
      fSync_q       <= 1'b0;
      dbLevel_q     <= 1'b0;
      dbLevelPrev_q <= 1'b0;
      dbCnt_q       <= '0;
    end else begin
      fMeta_q       <= js_button_f;
      fSync_q       <= fMeta_q;
      dbLevel_q     <= dbLevel_d;
      dbLevelPrev_q <= dbLevel_q;
      dbCnt_q       <= dbCnt_d;
    end
  end

  assign modePress = dbLevel_q & ~dbLevelPrev_q;

  always_comb begin
    state_d   = state_q;
    logoCnt_d = logoCnt_q;
    case (state_q)
      LOGO: begin
        if (modePress || (logoCnt_q == LogoLast)) begin
          state_d = BTN;
        end else begin
          logoCnt_d = logoCnt_q + LogoW'(1);
        end
      end
      BTN: if (modePress) state_d = ACC;
      ACC: if (modePress) state_d = JOY;
      JOY: if (modePress) state_d = BTN;
      default: state_d = LOGO;
    endcase
  end

  assign tick      = (stepCnt_q == StepLast);
  assign stepCnt_d = tick ? '0 : stepCnt_q + StepW'(1);

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q   <= LOGO;
      logoCnt_q <= '0;
      stepCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      logoCnt_q <= logoCnt_d;
      stepCnt_q <= stepCnt_d;
    end
  end

  // Screen rows grow downward, so "up" on every source maps to dy = -1.
  always_comb begin
    dirX = STEP_ZERO;
    dirY = STEP_ZERO;
    case (state_q)
      BTN: begin
        if (!btnD_q)      dirX = STEP_NEG;
        else if (!btnB_q) dirX = STEP_POS;
        if (!btnC_q)      dirY = STEP_POS;
        else if (!btnA_q) dirY = STEP_NEG;
      end
      ACC: begin
        if (accX_q == 8'h00)      dirX = STEP_NEG;
        else if (accX_q == 8'hFF) dirX = STEP_POS;
        if (accY_q == 8'h00)      dirY = STEP_POS;
        else if (accY_q == 8'hFF) dirY = STEP_NEG;
      end
      JOY: begin
        if (joyX_q > 8'hF0)      dirX = STEP_POS;
        else if (joyX_q < 8'h1F) dirX = STEP_NEG;
        if (joyY_q > 8'hF0)      dirY = STEP_NEG;
        else if (joyY_q < 8'h1F) dirY = STEP_POS;
      end
      default: ;
    endcase
  end

  assign accept     = moveValid_q & move_ready;
  assign sampleTick = tick & (state_q != LOGO);

  // A tick landing on the acceptance clock is discarded rather than counted as an overrun.
  always_comb begin
    moveValid_d = moveValid_q;
    moveDx_d    = moveDx_q;
    moveDy_d    = moveDy_q;
    overrun_d   = overrun_q;
    if (accept) begin
      moveValid_d = 1'b0;
    end
    if (sampleTick && !moveValid_q && ((dirX != STEP_ZERO) || (dirY != STEP_ZERO))) begin
      moveValid_d = 1'b1;
      moveDx_d    = dirX;
      moveDy_d    = dirY;
    end
    if (sampleTick && moveValid_q && !accept && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      moveValid_q <= 1'b0;
      moveDx_q    <= STEP_ZERO;
      moveDy_q    <= STEP_ZERO;
      overrun_q   <= 8'h00;
    end else begin
      moveValid_q <= moveValid_d;
      moveDx_q    <= moveDx_d;
      moveDy_q    <= moveDy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign move_valid  = moveValid_q;
  assign move_dx     = moveDx_q;
  assign move_dy     = moveDy_q;
  assign regime      = state_q;
  assign logo_active = (state_q == LOGO);
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_demo_input_scheduler.sv
// Directed self-checking bench for demo_input_scheduler using small test parameters
// (STEP_DIV=4, DEBOUNCE_CYCLES=3, LOGO_CYCLES=10); outputs sampled on the falling edge.
module tb_demo_input_scheduler;

  logic        vga_clk = 1'b0;
  logic        rst;
  logic        js_button_a, js_button_b, js_button_c, js_button_d;
  logic        js_button_f;
  logic [11:0] joystick_data_x, joystick_data_y;
  logic [15:0] accel_data_x, accel_data_y;
  logic        move_ready;
  logic        move_valid;
  logic [1:0]  move_dx, move_dy;
  logic [1:0]  regime;
  logic        logo_active;
  logic [7:0]  overrun_cnt;

  int checksTotal  = 0;
  int checksPassed = 0;

  always #5 vga_clk = ~vga_clk;

  demo_input_scheduler #(
    .LOGO_CYCLES    (10),
    .STEP_DIV       (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .vga_clk        (vga_clk),
    .rst            (rst),
    .js_button_a    (js_button_a),
    .js_button_b    (js_button_b),
    .js_button_c    (js_button_c),
    .js_button_d    (js_button_d),
    .js_button_f    (js_button_f),
    .joystick_data_x(joystick_data_x),
    .joystick_data_y(joystick_data_y),
    .accel_data_x   (accel_data_x),
    .accel_data_y   (accel_data_y),
    .move_ready     (move_ready),
    .move_valid     (move_valid),
    .move_dx        (move_dx),
    .move_dy        (move_dy),
    .regime         (regime),
    .logo_active    (logo_active),
    .overrun_cnt    (overrun_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Button nibble is {d, c, b, a}, active-low.
  task automatic applyStimulus(input logic [3:0] btnDcbaN, input logic [11:0] jx, input logic [11:0] jy,
                               input logic [15:0] ax, input logic [15:0] ay);
    {js_button_d, js_button_c, js_button_b, js_button_a} = btnDcbaN;
    joystick_data_x = jx;
    joystick_data_y = jy;
    accel_data_x    = ax;
    accel_data_y    = ay;
  endtask

  task automatic sampleWindow(input int n, output int nValid, output int maxRun,
                              output logic [1:0] dxSeen, output logic [1:0] dySeen);
    int run;
    run    = 0;
    nValid = 0;
    maxRun = 0;
    dxSeen = 2'b00;
    dySeen = 2'b00;
    for (int i = 0; i < n; i++) begin
      @(negedge vga_clk);
      if (move_valid) begin
        nValid++;
        run++;
        if (run > maxRun) maxRun = run;
        dxSeen = move_dx;
        dySeen = move_dy;
      end else begin
        run = 0;
      end
    end
  endtask

  // Settle after new inputs, then expect two requests per 8 clocks (or none).
  task automatic checkDirection(input string tag, input int expValid,
                                input logic [1:0] expDx, input logic [1:0] expDy);
    int nValid, maxRun;
    logic [1:0] dxSeen, dySeen;
    repeat (5) @(negedge vga_clk);
    sampleWindow(8, nValid, maxRun, dxSeen, dySeen);
    checkOutput({tag, " count"}, nValid, expValid);
    if (expValid != 0) begin
      checkOutput({tag, " dx"}, dxSeen, expDx);
      checkOutput({tag, " dy"}, dySeen, expDy);
    end
  endtask

  task automatic checkLogoPhase(input string tag);
    int  logoCycles;
    bit  sawValid;
    logoCycles = 1;
    sawValid   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge vga_clk);
      if (regime == 2'b00 && logo_active) begin
        logoCycles++;
        if (move_valid) sawValid = 1'b1;
      end else begin
        break;
      end
    end
    checkOutput({tag, " logo cycles"}, logoCycles, 10);
    checkOutput({tag, " regime after logo"}, regime, 2'b11);
    checkOutput({tag, " logo_active after logo"}, logo_active, 1'b0);
    checkOutput({tag, " no valid in logo"}, sawValid, 1'b0);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    @(negedge vga_clk);
    checkOutput({tag, " move_valid"}, move_valid, 1'b0);
    checkOutput({tag, " move_dx"}, move_dx, 2'b00);
    checkOutput({tag, " move_dy"}, move_dy, 2'b00);
    checkOutput({tag, " regime"}, regime, 2'b00);
    checkOutput({tag, " logo_active"}, logo_active, 1'b1);
    checkOutput({tag, " overrun_cnt"}, overrun_cnt, 8'd0);
    rst = 1'b0;
    checkLogoPhase(tag);
  endtask

  task automatic pressF(input int holdCycles);
    js_button_f = 1'b1;
    repeat (holdCycles) @(negedge vga_clk);
    js_button_f = 1'b0;
    repeat (12) @(negedge vga_clk);
  endtask

  task automatic waitValid(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (move_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge vga_clk);
    end
    checkOutput({tag, " valid seen"}, ok, 1'b1);
  endtask

  initial begin
    int nValid, maxRun;
    logic [1:0] dxSeen, dySeen;
    bit stable;

    rst         = 1'b1;
    js_button_f = 1'b0;
    move_ready  = 1'b1;
    applyStimulus(4'hF, 12'h800, 12'h800, 16'h8000, 16'h8000);
    doReset("reset");

    applyStimulus(4'b1001, 12'h800, 12'h800, 16'h8000, 16'h8000);
    repeat (5) @(negedge vga_clk);
    sampleWindow(16, nValid, maxRun, dxSeen, dySeen);
    checkOutput("btn b+c count", nValid, 4);
    checkOutput("btn b+c pulse width", maxRun, 1);
    checkOutput("btn b+c dx", dxSeen, 2'b01);
    checkOutput("btn b+c dy", dySeen, 2'b01);

    applyStimulus(4'b0000, 12'h800, 12'h800, 16'h8000, 16'h8000);
    checkDirection("btn all", 2, 2'b11, 2'b01);
    applyStimulus(4'b1110, 12'h800, 12'h800, 16'h8000, 16'h8000);
    checkDirection("btn a only", 2, 2'b00, 2'b11);
    applyStimulus(4'hF, 12'h800, 12'h800, 16'h8000, 16'h8000);
    checkDirection("btn none", 0, 2'b00, 2'b00);

    pressF(2);
    checkOutput("short press regime", regime, 2'b11);
    pressF(6);
    checkOutput("press1 regime", regime, 2'b10);
    pressF(6);
    checkOutput("press2 regime", regime, 2'b01);
    pressF(6);
    checkOutput("press3 regime", regime, 2'b11);
    pressF(6);
    checkOutput("press4 regime", regime, 2'b10);

    applyStimulus(4'hF, 12'h800, 12'h800, 16'h0012, 16'hFF34);
    checkDirection("acc 00/FF", 2, 2'b11, 2'b11);
    applyStimulus(4'hF, 12'h800, 12'h800, 16'hFFAB, 16'h00CD);
    checkDirection("acc FF/00", 2, 2'b01, 2'b01);
    applyStimulus(4'b0000, 12'h800, 12'h800, 16'h1234, 16'h80FF);
    checkDirection("acc center", 0, 2'b00, 2'b00);

    pressF(6);
    checkOutput("press5 regime", regime, 2'b01);
    applyStimulus(4'hF, 12'hFFF, 12'h800, 16'h0000, 16'h0000);
    checkDirection("joy FFF/800", 2, 2'b01, 2'b00);
    applyStimulus(4'hF, 12'h100, 12'hFF0, 16'h0000, 16'h0000);
    checkDirection("joy 100/FF0", 2, 2'b11, 2'b11);
    applyStimulus(4'hF, 12'h1F0, 12'h1E0, 16'h0000, 16'h0000);
    checkDirection("joy 1F0/1E0", 2, 2'b00, 2'b01);
    applyStimulus(4'hF, 12'hF0F, 12'h800, 16'h0000, 16'h0000);
    checkDirection("joy F0F/800", 0, 2'b00, 2'b00);
    applyStimulus(4'hF, 12'h800, 12'h800, 16'h0000, 16'h0000);
    checkDirection("joy center", 0, 2'b00, 2'b00);

    applyStimulus(4'hF, 12'hFFF, 12'h800, 16'h0000, 16'h0000);
    repeat (5) @(negedge vga_clk);
    move_ready = 1'b0;
    waitValid("overrun", 10);
    stable = 1'b1;
    repeat (40) begin
      @(negedge vga_clk);
      if (!move_valid || move_dx != 2'b01 || move_dy != 2'b00) stable = 1'b0;
    end
    checkOutput("overrun after 10 ticks", overrun_cnt, 8'd10);
    checkOutput("held request stable 10", stable, 1'b1);
    repeat (1200) begin
      @(negedge vga_clk);
      if (!move_valid || move_dx != 2'b01 || move_dy != 2'b00) stable = 1'b0;
    end
    checkOutput("overrun saturated", overrun_cnt, 8'd255);
    checkOutput("held request stable 310", stable, 1'b1);
    move_ready = 1'b1;
    @(negedge vga_clk);
    checkOutput("valid drops after accept", move_valid, 1'b0);
    checkOutput("overrun after accept", overrun_cnt, 8'd255);

    move_ready = 1'b0;
    waitValid("mid-handshake", 10);
    doReset("mid-handshake reset");

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
